main_core: RTL and testbench

- Two-channel input conditioner driving two outputs; top-level board glue between raw pin inputs (buttons/switches) and output pins (LEDs).
- Each channel: synchronizer → debounce filter → output stage (level-follow or toggle).
- Channels are independent; no cross-channel logic.

---
 rtl/main_core_pkg.sv | 13 +
 rtl/main_core_input_conditioner.sv | 82 ++++++++
 rtl/main_core.sv | 41 ++++
 tb/tb_main_core.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/main_core_pkg.sv
// Shared definitions for the two-channel input conditioner.
// Mode encodings and the debounce counter width helper.
package main_core_pkg;

    localparam int MODE_LEVEL  = 0;
    localparam int MODE_TOGGLE = 1;

    // One spare bit so the counter can hold DEBOUNCE_CYCLES without wrapping.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/main_core_input_conditioner.sv
// One input channel: synchronizer, debounce filter and output stage.
// Output is always taken from a flop; no comb path from din to dout.
module input_conditioner
    import main_core_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MODE            = MODE_LEVEL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   d_q;
    logic                   d_n;
    logic [CW-1:0]          c_q;
    logic [CW-1:0]          c_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Accept on the DEBOUNCE_CYCLES-th consecutive deviating edge.
    always_comb begin
        d_n = d_q;
        c_n = '0;
        if (s != d_q) begin
            if (c_q == C_LAST) begin
                d_n = s;
            end else begin
                c_n = c_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
            c_q <= '0;
        end else begin
            d_q <= d_n;
            c_q <= c_n;
        end
    end

    generate
        if (MODE == MODE_TOGGLE) begin : g_toggle
            logic d_prev_q;
            logic out_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d_prev_q <= 1'b0;
                    out_q    <= 1'b0;
                end else begin
                    d_prev_q <= d_q;
                    if (d_q && !d_prev_q) begin
                        out_q <= !out_q;
                    end
                end
            end

            assign dout = out_q;
        end else begin : g_level
            assign dout = d_q;
        end
    endgenerate

endmodule

// File: rtl/main_core.sv
// Board glue: two independent conditioned input channels to two outputs.
// Each channel has its own synchronizer, debouncer and output mode.
module main_core
    import main_core_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MODE1           = MODE_LEVEL,
    parameter int MODE2           = MODE_LEVEL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in1,
    input  logic in2,
    output logic out1,
    output logic out2
);

    input_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .MODE            (MODE1)
    ) u_ch1 (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (in1),
        .dout  (out1)
    );

    input_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .MODE            (MODE2)
    ) u_ch2 (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (in2),
        .dout  (out2)
    );

endmodule

// File: tb/tb_main_core.sv
// Scoreboard bench: level-mode and toggle-mode instances share inputs.
// Expected output edges are queued at stimulus time and popped by a monitor.
module tb_main_core;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic in1   = 1'b0;
    logic in2   = 1'b0;
    logic lv1, lv2, tg1, tg2;

    main_core dut_lvl (
        .clk   (clk),
        .rst_n (rst_n),
        .in1   (in1),
        .in2   (in2),
        .out1  (lv1),
        .out2  (lv2)
    );

    main_core #(
        .MODE1 (1),
        .MODE2 (1)
    ) dut_tog (
        .clk   (clk),
        .rst_n (rst_n),
        .in1   (in1),
        .in2   (in2),
        .out1  (tg1),
        .out2  (tg2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;
    bit tog_st [2];

    typedef struct {
        bit v;
        int c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    // id: 0 = level out1, 1 = level out2, 2 = toggle out1, 3 = toggle out2
    task automatic push(input int id, input bit v, input int c);
        exp_t e;
        e.v = v;
        e.c = c;
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic check_evt(input int id, input bit v);
        exp_t e;
        bit   got;
        got = 1'b0;
        e.v = 1'b0;
        e.c = 0;
        case (id)
            0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); got = 1'b1; end
        endcase
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL evt_unexpected id=%0d got=%0b at cyc=%0d required=no change",
                     id, v, cyc);
        end else if (e.v != v || e.c != cyc) begin
            errors++;
            $display("FAIL evt id=%0d got=%0b@%0d required=%0b@%0d",
                     id, v, cyc, e.v, e.c);
        end
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%b required=%b at cyc=%0d", name, act, req, cyc);
        end
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] cur;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {tg2, tg1, lv2, lv1};
            if (rst_n && !done) begin
                for (int i = 0; i < 4; i++) begin
                    if (cur[i] !== prev[i]) check_evt(i, cur[i]);
                end
            end
            prev = cur;
        end
    end

    // Drive a pulse; acc says whether the debouncer should accept it.
    task automatic pulse(input bit a, input bit b, input int len, input bit acc);
        int n;
        @(negedge clk);
        #1;
        in1 = a;
        in2 = b;
        n = cyc;
        if (acc && a) begin
            push(0, 1'b1, n + 6);
            tog_st[0] = !tog_st[0];
            push(2, tog_st[0], n + 7);
        end
        if (acc && b) begin
            push(1, 1'b1, n + 6);
            tog_st[1] = !tog_st[1];
            push(3, tog_st[1], n + 7);
        end
        repeat (len) @(negedge clk);
        #1;
        in1 = 1'b0;
        in2 = 1'b0;
        n = cyc;
        if (acc && a) push(0, 1'b0, n + 6);
        if (acc && b) push(1, 1'b0, n + 6);
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        tog_st[0] = 1'b0;
        tog_st[1] = 1'b0;

        rst_n = 1'b0;
        in1   = 1'b1;
        in2   = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #2;
            chk("reset_hold", {tg2, tg1, lv2, lv1}, 4'b0000);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        in1 = 1'b0;
        in2 = 1'b0;
        gap(12);
        chk("post_release", {tg2, tg1, lv2, lv1}, 4'b0000);

        pulse(1'b1, 1'b0, 10, 1'b1);
        gap(15);
        pulse(1'b0, 1'b1, 10, 1'b1);
        gap(15);
        pulse(1'b1, 1'b0, 3, 1'b0);
        gap(15);
        pulse(1'b1, 1'b0, 4, 1'b1);
        gap(15);
        pulse(1'b1, 1'b1, 10, 1'b1);
        gap(15);
        pulse(1'b1, 1'b0, 10, 1'b1);
        gap(15);

        @(negedge clk);
        #1;
        in1 = 1'b1;
        n = cyc;
        push(0, 1'b1, n + 6);
        tog_st[0] = !tog_st[0];
        push(2, tog_st[0], n + 7);
        repeat (10) @(negedge clk);
        #1 in2 = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        chk("pre_reset_lv1", {3'b000, lv1}, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {tg2, tg1, lv2, lv1}, 4'b0000);
        tog_st[0] = 1'b0;
        tog_st[1] = 1'b0;
        in1 = 1'b0;
        in2 = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        gap(20);
        chk("after_reset_quiet", {tg2, tg1, lv2, lv1}, 4'b0000);

        done = 1'b1;
        chk("drain", {q3.size() != 0, q2.size() != 0, q1.size() != 0, q0.size() != 0},
            4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
